// File: rtl/uart_tx.sv
// uart_tx: serialises W_IN-bit parallel transfers into NUM_WORDS UART frames.
// Each frame is start(0), BITS_PER_WORD data bits LSB first, stop(1), and every
// bit is held for CLOCKS_PER_PULSE clocks. Word 0 (least-significant byte) goes
// out first, and consecutive words of one transfer have no idle gap between them.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line high, s_ready high, waiting for s_valid && s_ready
// SEND  | shifting the latched transfer out, frame after frame
module uart_tx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int W_IN             = 16,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W_IN-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            tx
);

    localparam int NUM_WORDS = W_IN / BITS_PER_WORD;

    // Counter widths are clamped to at least one bit so that the degenerate
    // cases CLOCKS_PER_PULSE == 1 and NUM_WORDS == 1 still elaborate.
    localparam int PW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW = $clog2(BITS_PER_WORD + 2);
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_DATA_LAST = BW'(BITS_PER_WORD);
    localparam logic [BW-1:0] BIT_STOP = BW'(BITS_PER_WORD + 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    logic [PW-1:0]   pulse_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [WW-1:0]   word_cnt;
    // Latched transfer; shifted right as data bits leave, so the next data
    // bit is always at position 0 regardless of which word is in flight.
    logic [W_IN-1:0] shreg;

    // Frame sequencer: all state, counters and both outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            tx        <= 1'b1;
            s_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        shreg     <= s_data;
                        pulse_cnt <= '0;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                        tx        <= 1'b0;
                        s_ready   <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        pulse_cnt <= '0;
                        if (bit_cnt == BIT_STOP) begin
                            bit_cnt <= '0;
                            if (word_cnt == WORD_LAST) begin
                                tx      <= 1'b1;
                                s_ready <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                // next word's start bit follows the stop bit directly
                                word_cnt <= word_cnt + 1'b1;
                                tx       <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_DATA_LAST) begin
                                tx <= 1'b1;
                            end else begin
                                tx    <= shreg[0];
                                shreg <= shreg >> 1;
                            end
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at default parameters. Expected line levels
// come from a frame-position model; a behavioural receiver checks loopback.
module tb_uart_tx;

    localparam int CPP = 4;
    localparam int W   = 16;
    localparam int BPW = 8;
    localparam int NW  = W / BPW;
    localparam int T   = NW * (BPW + 2) * CPP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          tx;

    int vectors = 0;
    int miscompares = 0;

    logic          rx_en = 1'b0;
    logic [7:0]    rx_bytes[$];
    int            rx_stop_err = 0;

    uart_tx #(.CLOCKS_PER_PULSE(CPP), .W_IN(W), .BITS_PER_WORD(BPW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .tx(tx)
    );

    always #5 clk = ~clk;

    // advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected line level n cycles after the accept edge for transfer d
    function automatic logic exp_tx(input logic [W-1:0] d, input int n);
        int unit, w, b;
        if (n >= T) return 1'b1;
        unit = n / CPP;
        w = unit / (BPW + 2);
        b = unit % (BPW + 2);
        if (b == 0) return 1'b0;
        if (b == BPW + 1) return 1'b1;
        return d[w * BPW + b - 1];
    endfunction

    // behavioural receiver: samples each bit at mid-pulse after a start edge
    initial begin
        logic [7:0] v;
        forever begin
            step();
            if (rx_en && tx === 1'b0) begin
                repeat (CPP / 2) step();
                for (int b = 0; b < BPW; b++) begin
                    repeat (CPP) step();
                    v[b] = tx;
                end
                repeat (CPP) step();
                if (tx !== 1'b1) rx_stop_err++;
                rx_bytes.push_back(v);
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (s_ready !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s wait_ready: s_ready=%b after %0d cycles, need 1", tag, s_ready, n);
        end
    endtask

    // accept d at the next edge, then check the whole transfer cycle by cycle
    task automatic send_check(input string tag, input logic [W-1:0] d, input bit scramble);
        wait_ready(tag);
        s_data = d;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        for (int n = 0; n < T; n++) begin
            vectors++;
            if (tx !== exp_tx(d, n) || s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s cycle %0d: tx=%b s_ready=%b, need tx=%b s_ready=0",
                         tag, n, tx, s_ready, exp_tx(d, n));
            end
            if (scramble) s_data = W'($urandom);
            step();
        end
        vectors++;
        if (tx !== 1'b1 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s end: tx=%b s_ready=%b, need tx=1 s_ready=1", tag, tx, s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = W'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (tx !== 1'b1 || s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset hold %0d: tx=%b s_ready=%b, need tx=1 s_ready=0", i, tx, s_ready);
            end
        end
        rst = 1'b0;
        step();
        vectors++;
        if (tx !== 1'b1 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset release: tx=%b s_ready=%b, need tx=1 s_ready=1", tx, s_ready);
        end
        s_valid = 1'b0;
        step();
        vectors++;
        if (tx !== 1'b1 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset no_start: tx=%b s_ready=%b, need tx=1 s_ready=1", tx, s_ready);
        end
    endtask

    task automatic test_idle();
        s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s_data = W'($urandom);
            step();
            vectors++;
            if (tx !== 1'b1 || s_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL idle %0d: tx=%b s_ready=%b, need tx=1 s_ready=1", i, tx, s_ready);
            end
        end
    endtask

    task automatic test_single();
        // hand-derived unit sequence for 16'hA53C
        logic [19:0] units = 20'b1_1010_0101_0_1_0011_1100_0;
        send_check("single", 16'hA53C, 1'b0);
        // spot-check the model against the hand sequence at each unit midpoint
        for (int u = 0; u < 20; u++) begin
            vectors++;
            if (exp_tx(16'hA53C, u * CPP + 1) !== units[u]) begin
                miscompares++;
                $display("FAIL single_units %0d: model=%b, need %b", u, exp_tx(16'hA53C, u * CPP + 1), units[u]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int high_run = 0;
        int n = 0;
        wait_ready("b2b");
        s_data = 16'h0001;
        s_valid = 1'b1;
        step();
        s_data = 16'hFFFF;
        // s_valid stays high: second accept must land at k+T+1
        while (n <= T) begin
            vectors++;
            if (n < T && tx !== exp_tx(16'h0001, n)) begin
                miscompares++;
                $display("FAIL b2b first cycle %0d: tx=%b, need %b", n, tx, exp_tx(16'h0001, n));
            end
            if (tx === 1'b1) high_run++;
            else high_run = 0;
            step();
            n++;
        end
        s_valid = 1'b0;
        vectors++;
        if (tx !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b second_accept: tx=%b s_ready=%b at k+%0d, need tx=0 s_ready=0", tx, s_ready, T + 1);
        end
        vectors++;
        if (high_run !== CPP + 1) begin
            miscompares++;
            $display("FAIL b2b gap: high cycles=%0d, need %0d", high_run, CPP + 1);
        end
        for (int m = 0; m < T; m++) begin
            vectors++;
            if (tx !== exp_tx(16'hFFFF, m)) begin
                miscompares++;
                $display("FAIL b2b second cycle %0d: tx=%b, need %b", m, tx, exp_tx(16'hFFFF, m));
            end
            step();
        end
    endtask

    task automatic test_stability();
        send_check("stability", 16'h1234, 1'b1);
    endtask

    task automatic test_reset_mid();
        wait_ready("rst_mid");
        s_data = 16'h0000;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        repeat (29) step();
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid pre: tx=%b, need 0", tx);
        end
        rst = 1'b1;
        s_valid = 1'b1;
        step();
        vectors++;
        if (tx !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid abort: tx=%b s_ready=%b, need tx=1 s_ready=0", tx, s_ready);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        step();
        send_check("rst_mid_after", 16'h00FF, 1'b0);
    endtask

    task automatic test_loopback();
        logic [W-1:0] sent[$];
        logic [W-1:0] got;
        rx_bytes.delete();
        rx_stop_err = 0;
        rx_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 100)) step();
            wait_ready("loopback");
            s_data = W'($urandom);
            sent.push_back(s_data);
            s_valid = 1'b1;
            step();
            s_valid = 1'b0;
            s_data = W'($urandom);
        end
        wait_ready("loopback_tail");
        repeat (10) step();
        rx_en = 1'b0;
        vectors++;
        if (rx_bytes.size() != 2 * sent.size() || rx_stop_err != 0) begin
            miscompares++;
            $display("FAIL loopback count: bytes=%0d stop_err=%0d, need bytes=%0d stop_err=0",
                     rx_bytes.size(), rx_stop_err, 2 * sent.size());
        end
        for (int i = 0; i < sent.size() && 2 * i + 1 < rx_bytes.size(); i++) begin
            got = {rx_bytes[2 * i + 1], rx_bytes[2 * i]};
            vectors++;
            if (got !== sent[i]) begin
                miscompares++;
                $display("FAIL loopback word %0d: got %h, need %h", i, got, sent[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_stability();
        for (int i = 0; i < 4; i++) send_check("random", W'($urandom), 1'b1);
        test_reset_mid();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // overall time bound so a stuck DUT cannot hang the run
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit, need completion");
        $fatal(1, "timeout");
    end

endmodule
